// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART: register addresses,
// CON bit positions and the frame state encoding used by both directions.
package uart_pkg;

    localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

    localparam int CON_TX_IE    = 0;
    localparam int CON_RX_IE    = 1;
    localparam int CON_TX_DONE  = 2;
    localparam int CON_RX_READY = 3;
    localparam int CON_TX_BUSY  = 4;
    localparam int CON_RX_OVR   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load arms it for a full or half bit period, and tick
// pulses in the last cycle of that period. Once expired it stays at zero until reloaded.
module uart_bit_timer #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic half,
    output logic tick
);

    localparam int            CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] FULL = CW'(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = half ? HALF : FULL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == ONE);

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART on the MEM-stage data bus: TXD/RXD/CON registers, 8N1 transmit
// and receive state machines, and a registered level interrupt.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irq
);

    localparam int DIV = CLK_HZ / BAUD;

    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_rxd, rd_con;
    logic unused_wdata;

    assign sel_txd = (addr == UART_TXD_ADDR);
    assign sel_rxd = (addr == UART_RXD_ADDR);
    assign sel_con = (addr == UART_CON_ADDR);
    assign wr_txd  = wr & sel_txd;
    assign wr_con  = wr & sel_con;
    assign rd_rxd  = rd & sel_rxd;
    assign rd_con  = rd & sel_con;
    assign unused_wdata = ^wdata[31:8];

    logic       tx_ie_q, rx_ie_q, tx_done_q, rx_ready_q, rx_ovr_q, irq_q;
    logic       tx_done_d, rx_ready_d, rx_ovr_d;
    logic [7:0] rxd_q;

    uart_state_e tx_state_q, tx_state_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic        tx_q, tx_d;
    logic        tx_load, tx_tick, tx_done_set;

    uart_state_e rx_state_q, rx_state_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic        rx_load, rx_half, rx_tick, rx_ready_set;

    uart_bit_timer #(.DIV(DIV)) u_tx_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tx_load),
        .half  (1'b0),
        .tick  (tx_tick)
    );

    uart_bit_timer #(.DIV(DIV)) u_rx_timer (
        .clk   (clk),
        .reset (reset),
        .load  (rx_load),
        .half  (rx_half),
        .tick  (rx_tick)
    );

    // Line level is derived from the next state so the start bit appears on the accepting edge.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_sh_d     = tx_sh_q;
        tx_bit_d    = tx_bit_q;
        tx_load     = 1'b0;
        tx_done_set = 1'b0;
        case (tx_state_q)
            IDLE: if (wr_txd) begin
                tx_state_d = START;
                tx_sh_d    = wdata[7:0];
                tx_load    = 1'b1;
            end
            START: if (tx_tick) begin
                tx_state_d = DATA;
                tx_bit_d   = 3'd0;
                tx_load    = 1'b1;
            end
            DATA: if (tx_tick) begin
                tx_load = 1'b1;
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = STOP;
                end else begin
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d = tx_bit_q + 3'd1;
                end
            end
            STOP: if (tx_tick) begin
                tx_state_d  = IDLE;
                tx_done_set = 1'b1;
            end
            default: tx_state_d = IDLE;
        endcase
        case (tx_state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = tx_sh_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Start bit is resampled at mid-bit; a high line there means the edge was a glitch.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_sh_d      = rx_sh_q;
        rx_bit_d     = rx_bit_q;
        rx_load      = 1'b0;
        rx_half      = 1'b0;
        rx_ready_set = 1'b0;
        case (rx_state_q)
            IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = START;
                rx_load    = 1'b1;
                rx_half    = 1'b1;
            end
            START: if (rx_tick) begin
                if (rx_s2_q) begin
                    rx_state_d = IDLE;
                end else begin
                    rx_state_d = DATA;
                    rx_bit_d   = 3'd0;
                    rx_load    = 1'b1;
                end
            end
            DATA: if (rx_tick) begin
                rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
                rx_load = 1'b1;
                if (rx_bit_q == 3'd7) begin
                    rx_state_d = STOP;
                end else begin
                    rx_bit_d = rx_bit_q + 3'd1;
                end
            end
            STOP: if (rx_tick) begin
                rx_state_d   = IDLE;
                rx_ready_set = rx_s2_q;
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // A flag set in the same cycle as its clearing read wins.
    assign tx_done_d  = tx_done_set | (tx_done_q & ~rd_con);
    assign rx_ready_d = rx_ready_set | (rx_ready_q & ~rd_rxd);
    assign rx_ovr_d   = (rx_ready_set & rx_ready_q) | (rx_ovr_q & ~rd_con);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= IDLE;
            tx_sh_q    <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
            rx_state_q <= IDLE;
            rx_sh_q    <= '0;
            rx_bit_q   <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            tx_ie_q    <= 1'b0;
            rx_ie_q    <= 1'b0;
            tx_done_q  <= 1'b0;
            rx_ready_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rxd_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_sh_q    <= rx_sh_d;
            rx_bit_q   <= rx_bit_d;
            rx_s1_q    <= UART_RX;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            if (wr_con) begin
                tx_ie_q <= wdata[CON_TX_IE];
                rx_ie_q <= wdata[CON_RX_IE];
            end
            tx_done_q  <= tx_done_d;
            rx_ready_q <= rx_ready_d;
            rx_ovr_q   <= rx_ovr_d;
            if (rx_ready_set) begin
                rxd_q <= rx_sh_q;
            end
            irq_q <= (tx_ie_q & tx_done_q) | (rx_ie_q & rx_ready_q);
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_rxd) begin
                rdata[7:0] = rxd_q;
            end else if (sel_con) begin
                rdata[CON_TX_IE]    = tx_ie_q;
                rdata[CON_RX_IE]    = rx_ie_q;
                rdata[CON_TX_DONE]  = tx_done_q;
                rdata[CON_RX_READY] = rx_ready_q;
                rdata[CON_TX_BUSY]  = (tx_state_q != IDLE);
                rdata[CON_RX_OVR]   = rx_ovr_q;
            end
        end
    end

    assign UART_TX = tx_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Directed-plus-random bench for uart_mmio at 16 clocks per bit, checked against
// a register-level model of the CON/RXD flags and an ideal 8N1 line waveform.
module tb_uart_mmio;

    localparam int          DIV   = 16;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;
    localparam logic [31:0] A_BAD = 32'h4000_0024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        UART_RX = 1'b1;
    logic        UART_TX;
    logic        irq;

    int total = 0;
    int bad = 0;

    bit         m_tx_ie, m_rx_ie, m_tx_done, m_rx_ready, m_ovr;
    logic [7:0] m_rxd;
    logic [7:0] rb;

    uart_mmio #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .UART_RX (UART_RX),
        .UART_TX (UART_TX),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_con(input bit busy);
        return {26'd0, m_ovr, busy, m_rx_ready, m_tx_done, m_rx_ie, m_tx_ie};
    endfunction

    function automatic logic exp_irq();
        return (m_tx_ie & m_tx_done) | (m_rx_ie & m_rx_ready);
    endfunction

    task automatic model_reset();
        m_tx_ie = 0; m_rx_ie = 0; m_tx_done = 0; m_rx_ready = 0; m_ovr = 0; m_rxd = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0; addr = '0; wdata = '0;
        if (a == A_CON) begin
            m_tx_ie = d[0];
            m_rx_ie = d[1];
        end
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        rd = 1'b1; addr = a;
        #1 check(tag, rdata, exp);
        @(negedge clk);
        rd = 1'b0; addr = '0;
        if (a == A_CON) begin
            m_tx_done = 0;
            m_ovr = 0;
        end
        if (a == A_RXD) m_rx_ready = 0;
    endtask

    // Sends b via TXD and compares the line against the ideal frame every cycle.
    // With intrude set, CON is polled for TX_BUSY and a second TXD write lands 8 cycles in.
    task automatic tx_frame(input logic [7:0] b, input bit intrude);
        logic expb;
        bus_write(A_TXD, {24'd0, b});
        for (int k = 0; k < 10 * DIV; k++) begin
            if (k < DIV) expb = 1'b0;
            else if (k < 9 * DIV) expb = b[(k - DIV) / DIV];
            else expb = 1'b1;
            if (intrude) begin
                if (k == 7) begin
                    rd = 1'b0; wr = 1'b1; addr = A_TXD; wdata = 32'h55;
                end else begin
                    wr = 1'b0; rd = 1'b1; addr = A_CON; wdata = '0;
                    #1 check("tx_busy", {31'd0, rdata[4]}, 32'd1);
                end
            end
            check("tx_line", {31'd0, UART_TX}, {31'd0, expb});
            if (k == 10 * DIV - 1) begin
                rd = 1'b0; wr = 1'b0; addr = '0;
            end
            @(negedge clk);
        end
        if (intrude) begin
            m_tx_done = 0;
            m_ovr = 0;
        end
        check("tx_idle_line", {31'd0, UART_TX}, 32'd1);
        m_tx_done = 1;
    endtask

    task automatic rx_send(input logic [7:0] b, input bit stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            UART_RX = fr[i];
            repeat (DIV) @(negedge clk);
        end
        UART_RX = 1'b1;
        if (stop_bit) begin
            if (m_rx_ready) m_ovr = 1;
            m_rx_ready = 1;
            m_rxd = b;
        end
    endtask

    initial begin
        model_reset();
        idle(3);
        check("rst_tx", {31'd0, UART_TX}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        addr = A_CON;
        #1 check("rst_rdata_nord", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        addr = '0;
        bus_read(A_CON, exp_con(0), "rst_con");
        bus_read(A_RXD, 32'd0, "rst_rxd");
        bus_read(A_TXD, 32'd0, "rst_txd");
        bus_read(A_BAD, 32'd0, "unmapped_rd");

        // Transmit 0xA5 with TX interrupt enabled.
        bus_write(A_CON, 32'h1);
        tx_frame(8'hA5, 1'b0);
        idle(2);
        check("tx_irq_set", {31'd0, irq}, {31'd0, exp_irq()});
        bus_read(A_CON, 32'h05, "con_after_tx");
        idle(1);
        check("tx_irq_clr", {31'd0, irq}, 32'd0);
        bus_read(A_CON, 32'h01, "con_second");

        // Overlapping TXD write is dropped; busy throughout.
        tx_frame(8'h3C, 1'b1);
        idle(2);
        check("tx2_irq", {31'd0, irq}, {31'd0, exp_irq()});
        bus_read(A_CON, exp_con(0), "con_after_tx2");
        idle(2);
        check("tx2_line_idle", {31'd0, UART_TX}, 32'd1);

        for (int n = 0; n < 2; n++) begin
            rb = 8'($urandom);
            tx_frame(rb, 1'b0);
            idle(2);
            check("txr_irq", {31'd0, irq}, {31'd0, exp_irq()});
            bus_read(A_CON, exp_con(0), "txr_con");
        end

        // Receive 0x5A with RX interrupt enabled.
        bus_write(A_CON, 32'h2);
        rx_send(8'h5A, 1'b1);
        idle(2);
        check("rx_irq_set", {31'd0, irq}, {31'd0, exp_irq()});
        bus_read(A_CON, exp_con(0), "rx_con");
        bus_read(A_RXD, {24'd0, m_rxd}, "rx_rxd");
        idle(1);
        check("rx_irq_clr", {31'd0, irq}, {31'd0, exp_irq()});
        bus_read(A_CON, exp_con(0), "rx_con_clr");

        // Two frames without a read between them: overrun.
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        idle(2);
        bus_read(A_CON, exp_con(0), "ovr_con");
        bus_read(A_CON, exp_con(0), "ovr_con_clr");
        bus_read(A_RXD, {24'd0, m_rxd}, "ovr_rxd");

        for (int n = 0; n < 2; n++) begin
            rb = 8'($urandom);
            rx_send(rb, 1'b1);
            idle(2);
            check("rxr_irq", {31'd0, irq}, {31'd0, exp_irq()});
            bus_read(A_RXD, {24'd0, m_rxd}, "rxr_rxd");
        end

        // Short low glitch, then a frame with a low stop bit.
        UART_RX = 1'b0;
        idle(5);
        UART_RX = 1'b1;
        idle(30);
        bus_read(A_CON, exp_con(0), "glitch_con");
        check("glitch_irq", {31'd0, irq}, {31'd0, exp_irq()});
        rx_send(8'hC3, 1'b0);
        idle(20);
        bus_read(A_CON, exp_con(0), "frame_err_con");
        bus_read(A_RXD, {24'd0, m_rxd}, "frame_err_rxd");

        // Both strobes at once, then an unmapped write.
        @(negedge clk);
        rd = 1'b1; wr = 1'b1; addr = A_CON; wdata = 32'h3;
        #1 check("both_rdata", rdata, exp_con(0));
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        m_tx_done = 0; m_ovr = 0; m_tx_ie = 1; m_rx_ie = 1;
        bus_write(A_BAD, 32'h0);
        bus_read(A_CON, exp_con(0), "both_con");

        // Reset in the middle of a transmit frame.
        bus_write(A_TXD, 32'hF0);
        idle(40);
        check("mid_tx_low", {31'd0, UART_TX}, 32'd0);
        reset = 1'b0;
        #1 check("rst_mid_tx", {31'd0, UART_TX}, 32'd1);
        rd = 1'b1; addr = A_CON;
        #1 check("rst_mid_con", rdata, 32'd0);
        check("rst_mid_irq", {31'd0, irq}, 32'd0);
        rd = 1'b0; addr = '0;
        model_reset();
        idle(2);
        reset = 1'b1;
        bus_read(A_CON, exp_con(0), "post_rst_con");
        bus_read(A_RXD, 32'd0, "post_rst_rxd");
        idle(DIV * 2);
        check("post_rst_line", {31'd0, UART_TX}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
